// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder: window base, word offsets
// and STATUS bit positions.
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

  localparam logic [5:0] OFF_STATUS  = 6'h00;
  localparam logic [5:0] OFF_RX_DATA = 6'h01;
  localparam logic [5:0] OFF_TX_DATA = 6'h02;
  localparam logic [5:0] OFF_CYCLE   = 6'h04;
  localparam logic [5:0] OFF_INSTRET = 6'h05;
  localparam logic [5:0] OFF_CNT_RST = 6'h06;

  localparam int ST_TX_NFULL  = 0;
  localparam int ST_RX_NEMPTY = 1;
  localparam int ST_TX_OVF    = 2;

endpackage

// File: rtl/mmio_responder_fifo.sv
// Synchronous byte FIFO with extra-MSB pointers; a push while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic do_push, do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + ONE;
    if (do_pop)  rd_d = rd_q + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: UART TX/RX byte FIFOs plus cycle and instret counters
// behind a word-addressed window; load data returns one cycle later.
module mmio_responder #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = mmio_pkg::MMIO_BASE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic        inst_retire,
  output logic [31:0] rsp_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  import mmio_pkg::*;

  logic       claim, rd, wr;
  logic [5:0] off;
  logic       sel_status, sel_rx, sel_tx;
  logic       sel_cycle, sel_inst, sel_crst;
  logic       tx_push, tx_full, tx_empty;
  logic       rx_pop, rx_full, rx_empty;
  logic [7:0] rx_head;
  logic       cnt_rst;

  logic        ovf_q, ovf_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] rdata_q, rdata_d;

  logic unused_ok;
  assign unused_ok = ^{req_addr[27:8], req_addr[1:0],
                       req_wdata[31:8], req_wstrb[3:1]};

  assign claim = req_valid &&
                 (req_addr[31:28] == MMIO_BASE[31:28]);
  assign rd  = claim && !req_we;
  assign wr  = claim && req_we;
  assign off = req_addr[7:2];

  assign sel_status = (off == OFF_STATUS);
  assign sel_rx     = (off == OFF_RX_DATA);
  assign sel_tx     = (off == OFF_TX_DATA);
  assign sel_cycle  = (off == OFF_CYCLE);
  assign sel_inst   = (off == OFF_INSTRET);
  assign sel_crst   = (off == OFF_CNT_RST);

  assign tx_push  = wr && sel_tx && req_wstrb[0];
  assign rx_pop   = rd && sel_rx && !rx_empty;
  assign cnt_rst  = wr && sel_crst;
  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_ready),
    .wdata (req_wdata[7:0]),
    .head  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_valid && rx_ready),
    .pop   (rx_pop),
    .wdata (rx_data),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (wr && sel_status) ovf_d = 1'b0;
    // full implies non-empty, so tx_ready means a pop frees a slot
    if (tx_push && tx_full && !tx_ready) ovf_d = 1'b1;

    cycle_d   = cnt_rst ? '0 : cycle_q + 32'd1;
    instret_d = cnt_rst ? '0 : instret_q + {31'd0, inst_retire};

    rdata_d = '0;
    if (rd) begin
      unique case (1'b1)
        sel_status: begin
          rdata_d[ST_TX_NFULL]  = !tx_full;
          rdata_d[ST_RX_NEMPTY] = !rx_empty;
          rdata_d[ST_TX_OVF]    = ovf_q;
        end
        sel_rx:    rdata_d = rx_empty ? '0 : {24'd0, rx_head};
        sel_cycle: rdata_d = cycle_q;
        sel_inst:  rdata_d = instret_q;
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q     <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
      rdata_q   <= '0;
    end else begin
      ovf_q     <= ovf_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rsp_rdata = rdata_q;

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O responder on the core's data-memory port. It answers execute-stage load/store requests whose address falls in the MMIO window. It returns read data in the writeback stage one cycle later. Internally it holds a UART TX byte FIFO, a UART RX byte FIFO, a cycle counter and a retired-instruction counter. It connects the pipeline to the UART transmitter and receiver blocks through ready/valid byte streams.

## Interface
- FIFO_DEPTH, 8: entries per byte FIFO; power of two, ≥2.
- MMIO_BASE, 32'h8000_0000: window base; request is claimed when req_addr[31:28] == MMIO_BASE[31:28].
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute-stage memory access valid (load or store).
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; bits [1:0] ignored (word access only).
- req_wdata  in  32  store data.
- req_wstrb  in  4  store byte strobes; TX push requires wstrb[0].
- inst_retire  in  1  one pulse per retired instruction (writeback valid).
- rsp_rdata  out  32  load data, valid in the cycle after the request.
- tx_data  out  8  head of TX FIFO.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  transmitter accepts byte.
- rx_data  in  8  received byte.
- rx_valid  in  1  receiver presents byte.
- rx_ready  out  1  RX FIFO not full.

## Operation
- Register map (offset from MMIO_BASE, decode addr[7:2]):
  - 0x00 STATUS (R): bit0 = TX FIFO not full; bit1 = RX FIFO not empty; bit2 = sticky TX overflow; other bits 0. Any write clears bit2.
  - 0x04 RX_DATA (R): {24'b0, RX head}. The read pops the RX FIFO if it is non-empty. If the FIFO is empty, the read returns 0 and nothing is popped.
  - 0x08 TX_DATA (W): pushes req_wdata[7:0] when wstrb[0]=1. Push when full: byte is dropped and overflow is set.
  - 0x10 CYCLE (R): free-running 32-bit counter, +1 every clk, wraps.
  - 0x14 INSTRET (R): +1 per inst_retire, wraps.
  - 0x18 CNT_RST (W): any claimed write sets CYCLE and INSTRET to 0.
- Unmapped offsets: reads return 0; writes have no effect.
- A load has side effects (RX pop) only when req_valid=1, req_we=0 and the request is claimed.
- TX stream: tx_valid = !tx_empty; pop on tx_valid && tx_ready.
- RX stream: push on rx_valid && rx_ready.
- Simultaneous push and pop on one FIFO: both happen and the occupancy is unchanged. This applies even when the FIFO is full, for the TX path: a CPU push together with a transmitter pop is accepted.
- CNT_RST in the same cycle as an increment: the reset wins. The counter is 0 in the following cycle.

## Timing
- rsp_rdata is registered. Request in cycle N gives data in cycle N+1.
- CYCLE and INSTRET reads sample the value at cycle N.
- rsp_rdata is 0 in any cycle not preceded by a claimed load.
- STATUS read in cycle N reflects FIFO state at the start of cycle N, before that cycle's push or pop.
- A byte pushed in cycle N is visible on tx_valid/tx_data in cycle N+1. A byte popped from RX in cycle N frees rx_ready in N+1.
- Reset (async assert, sync deassert by integration) puts the block in this state:
  - FIFOs empty; tx_valid=0; rx_ready=1.
  - Overflow=0; CYCLE=INSTRET=0; rsp_rdata=0.
  - Reset mid-transfer discards all FIFO contents.

## Structure
- Package mmio_pkg: MMIO_BASE, offset constants (STATUS, RX_DATA, TX_DATA, CYCLE, INSTRET, CNT_RST), STATUS bit indices.
- Sub-module sync_fifo (width, depth params; push/pop/full/empty/head):
  - Instantiated twice, TX and RX.
  - Pointers are log2(DEPTH)+1 bits; full/empty come from the MSB compare.

## Test plan
- Reset, then load STATUS → rsp_rdata = 32'h1 next cycle; tx_valid=0, rx_ready=1.
- Store 0x41, 0x42 to TX_DATA with tx_ready=0, then raise tx_ready → tx_data 0x41 then 0x42 on consecutive cycles, then tx_valid=0.
- With tx_ready=0, push 9 bytes (depth 8) → STATUS = 32'h4 (bit0=0, bit2=1). Any write to STATUS → bit2 clears.
- Drive rx_valid with 0x55, then load RX_DATA twice → rsp_rdata = 0x55, then 0. STATUS bit1 goes 1 → 0.
- Run 100 cycles with 10 inst_retire pulses, then store CNT_RST → both counters read 0 one cycle later. Next CYCLE read increments from there.
- Full TX FIFO, CPU push and tx pop in the same cycle → push accepted, no overflow, occupancy stays 8.
